// File: rtl/ycr_mem_router_pkg.sv
// Shared router types: FSM state, ycr_memif response codes and the burst-length helper.
package ycr_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] YCR_MEMIF_NOTRDY = 2'd0;
    localparam logic [1:0] YCR_MEMIF_RDY_OK = 2'd1;
    localparam logic [1:0] YCR_MEMIF_RDY_ER = 2'd2;
    localparam logic [1:0] YCR_MEMIF_RDY_LOK = 2'd3;

    typedef enum logic [1:0] {
        RESP_NOTRDY = YCR_MEMIF_NOTRDY,
        RESP_OK     = YCR_MEMIF_RDY_OK,
        RESP_ER     = YCR_MEMIF_RDY_ER,
        RESP_LOK    = YCR_MEMIF_RDY_LOK
    } resp_t;

    // A zero-length burst is treated as a single beat, as is any port forced to single-beat.
    function automatic logic [31:0] eff_bl(input logic single, input logic [31:0] bl);
        return (single || (bl == 32'd0)) ? 32'd1 : bl;
    endfunction

endpackage

// File: rtl/ycr_mem_router_if.sv
// Core-side (m_*) and downstream (s_*) ycr_memif buses of the router.
interface ycr_mem_router_if #(
    parameter int NUM_PORTS = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BLW       = 3
);
    logic [NUM_PORTS-1:0]     m_req;
    logic [NUM_PORTS-1:0]     m_cmd;
    logic [2*NUM_PORTS-1:0]   m_width;
    logic [AW*NUM_PORTS-1:0]  m_addr;
    logic [BLW*NUM_PORTS-1:0] m_bl;
    logic [NUM_PORTS-1:0]     m_req_ack;
    logic [DW*NUM_PORTS-1:0]  m_rdata;
    logic [2*NUM_PORTS-1:0]   m_resp;

    logic                     s_req;
    logic                     s_cmd;
    logic [1:0]               s_width;
    logic [AW-1:0]            s_addr;
    logic [BLW-1:0]           s_bl;
    logic                     s_req_ack;
    logic [DW-1:0]            s_rdata;
    logic [1:0]               s_resp;

    // Environment view: core masters plus downstream memory.
    modport master (
        output m_req, m_cmd, m_width, m_addr, m_bl, s_req_ack, s_rdata, s_resp,
        input  m_req_ack, m_rdata, m_resp, s_req, s_cmd, s_width, s_addr, s_bl
    );

    // Router view.
    modport slave (
        input  m_req, m_cmd, m_width, m_addr, m_bl, s_req_ack, s_rdata, s_resp,
        output m_req_ack, m_rdata, m_resp, s_req, s_cmd, s_width, s_addr, s_bl
    );
endinterface

// File: rtl/ycr_mem_router_arb.sv
// Round-robin / fixed-priority request picker.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module ycr_rr_arb #(
    parameter int NUM_PORTS = 2,
    parameter bit RR_EN     = 1'b1,
    parameter int IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        gnt_idx
);
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        // Walk from lowest to highest priority so the last hit (highest priority) wins.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = RR_EN ? ((int'(ptr) + k) % NUM_PORTS) : k;
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/ycr_mem_router.sv
// N-port ycr_memif router onto one downstream port with burst tracking and a response watchdog.
// Latency: one IDLE arbitration cycle to s_req; request fields, acks and responses pass through combinationally.
// Backpressure: s_req_ack gates the granted master; non-granted masters wait, there is no preemption.
module ycr_mem_router
    import ycr_router_pkg::*;
#(
    parameter int                   NUM_PORTS   = 2,
    parameter int                   AW          = 32,
    parameter int                   DW          = 32,
    parameter int                   BLW         = 3,
    parameter bit                   RR_EN       = 1'b1,
    parameter logic [NUM_PORTS-1:0] SINGLE_MASK = 2'b10,
    parameter int                   TIMEOUT     = 256
) (
    input  logic             clk,
    input  logic             rst,
    ycr_mem_router_if.slave  bus,
    output logic             busy,
    output logic             timeout_evt
);
    localparam int IW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t               state, state_nxt;
    logic [IW-1:0]        ptr, gnt_idx, arb_idx;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [BLW-1:0]       beat_cnt, bl_eff;
    logic [WDW-1:0]       wdog;
    logic                 sel_req, resp_vld, resp_term, wd_hit, accept, done;

    ycr_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .RR_EN     (RR_EN),
        .IW        (IW)
    ) u_arb (
        .req     (bus.m_req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    assign sel_req   = bus.m_req[gnt_idx];
    assign bl_eff    = BLW'(eff_bl(SINGLE_MASK[gnt_idx], 32'(bus.m_bl[int'(gnt_idx)*BLW +: BLW])));
    assign resp_vld  = (bus.s_resp != RESP_NOTRDY);
    assign resp_term = (bus.s_resp == RESP_LOK) || (bus.s_resp == RESP_ER) ||
                       ((bus.s_resp == RESP_OK) && (beat_cnt == BLW'(1)));
    assign wd_hit    = (TIMEOUT != 0) && (wdog == WDW'(TIMEOUT));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        done          = 1'b0;
        timeout_evt   = 1'b0;
        bus.s_req     = 1'b0;
        bus.s_cmd     = 1'b0;
        bus.s_width   = '0;
        bus.s_addr    = '0;
        bus.s_bl      = '0;
        bus.m_req_ack = '0;
        bus.m_rdata   = '0;
        bus.m_resp    = '0;
        case (state)
            IDLE: begin
                if (|arb_gnt) state_nxt = REQ;
            end
            REQ: begin
                bus.s_req              = sel_req;
                bus.s_cmd              = bus.m_cmd[gnt_idx];
                bus.s_width            = bus.m_width[int'(gnt_idx)*2 +: 2];
                bus.s_addr             = bus.m_addr[int'(gnt_idx)*AW +: AW];
                bus.s_bl               = bl_eff;
                bus.m_req_ack[gnt_idx] = sel_req & bus.s_req_ack;
                if (!sel_req) begin
                    state_nxt = IDLE;
                end else if (bus.s_req_ack) begin
                    accept    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (wd_hit) begin
                    bus.m_resp[int'(gnt_idx)*2 +: 2] = RESP_ER;
                    timeout_evt = 1'b1;
                    done        = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    bus.m_rdata[int'(gnt_idx)*DW +: DW] = bus.s_rdata;
                    bus.m_resp[int'(gnt_idx)*2 +: 2]    = (bus.s_resp == RESP_LOK) ? RESP_OK : bus.s_resp;
                    if (resp_term) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            gnt_idx  <= '0;
            beat_cnt <= '0;
            wdog     <= '0;
        end else begin
            if ((state == IDLE) && (|arb_gnt)) gnt_idx <= arb_idx;
            if (accept)
                beat_cnt <= bl_eff;
            else if ((state == RESP) && resp_vld && !wd_hit)
                beat_cnt <= beat_cnt - BLW'(1);
            // Only consecutive NOTRDY cycles in RESP count; any beat or exit clears it.
            if ((TIMEOUT != 0) && (state == RESP) && !done && !resp_vld)
                wdog <= wdog + WDW'(1);
            else
                wdog <= '0;
            if (done) ptr <= (gnt_idx == IW'(NUM_PORTS - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_ycr_mem_router.sv
module tb_ycr_mem_router;
    import ycr_router_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic fx_en;
    logic busy, tev, busy_fx, tev_fx;
    always #5 clk = ~clk;

    typedef struct packed { logic [1:0] gnt; logic [31:0] addr; logic [2:0] bl; } acc_t;
    typedef struct packed { logic [3:0] resp; logic [63:0] rdata; } rsp_t;

    acc_t       exp_acc[$];
    rsp_t       exp_rsp[$];
    logic [1:0] exp_fx[$];
    int checks  = 0;
    int errors  = 0;
    int tev_cnt = 0;

    ycr_mem_router_if #(.NUM_PORTS(2), .AW(32), .DW(32), .BLW(3)) bi ();
    ycr_mem_router_if #(.NUM_PORTS(2), .AW(32), .DW(32), .BLW(3)) bf ();

    assign bf.m_req     = fx_en ? bi.m_req : 2'b00;
    assign bf.m_cmd     = bi.m_cmd;
    assign bf.m_width   = bi.m_width;
    assign bf.m_addr    = bi.m_addr;
    assign bf.m_bl      = bi.m_bl;
    assign bf.s_req_ack = bi.s_req_ack;
    assign bf.s_rdata   = bi.s_rdata;
    assign bf.s_resp    = bi.s_resp;

    ycr_mem_router #(.NUM_PORTS(2), .AW(32), .DW(32), .BLW(3), .RR_EN(1'b1),
                     .SINGLE_MASK(2'b10), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .bus(bi.slave), .busy(busy), .timeout_evt(tev));

    ycr_mem_router #(.NUM_PORTS(2), .AW(32), .DW(32), .BLW(3), .RR_EN(1'b0),
                     .SINGLE_MASK(2'b10), .TIMEOUT(8)) dut_fx (
        .clk(clk), .rst(rst), .bus(bf.slave), .busy(busy_fx), .timeout_evt(tev_fx));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: pop the oldest expectation whenever the DUT shows an output event.
    always @(negedge clk) begin
        acc_t       ea;
        rsp_t       er;
        logic [1:0] ef;
        if (!rst && bi.s_req && bi.s_req_ack) begin
            if (exp_acc.size() == 0) unexpected("accept");
            else begin
                ea = exp_acc.pop_front();
                check("accept", 64'({bi.m_req_ack, bi.s_addr, bi.s_bl}), 64'(ea));
            end
        end
        if (!rst && (bi.m_resp != 4'd0)) begin
            if (exp_rsp.size() == 0) unexpected("resp");
            else begin
                er = exp_rsp.pop_front();
                check("resp", 64'(bi.m_resp), 64'(er.resp));
                check("rdata", bi.m_rdata, er.rdata);
            end
        end
        if (!rst && bf.s_req && bf.s_req_ack) begin
            if (exp_fx.size() == 0) unexpected("fx_grant");
            else begin
                ef = exp_fx.pop_front();
                check("fx_grant", 64'(bf.m_req_ack), 64'(ef));
            end
        end
        if (tev) tev_cnt++;
    end

    task automatic push_rsp(input int p, input logic [1:0] r, input logic [31:0] rd);
        rsp_t e;
        e.resp  = 4'(32'(r) << (2 * p));
        e.rdata = 64'(rd) << (32 * p);
        exp_rsp.push_back(e);
    endtask

    task automatic run_txn(input int p, input logic [31:0] addr, input logic [2:0] bl,
                           input logic [2:0] exp_bl, input logic [15:0] rsq, input int nr,
                           input logic [31:0] rd0);
        logic [1:0] r;
        tick;
        bi.m_req[p]            = 1'b1;
        bi.m_cmd[p]            = 1'b0;
        bi.m_width[p*2 +: 2]   = 2'd2;
        bi.m_addr[p*32 +: 32]  = addr;
        bi.m_bl[p*3 +: 3]      = bl;
        exp_acc.push_back(acc_t'({2'(1 << p), addr, exp_bl}));
        @(negedge clk);
        check("idle_arb_sreq", 64'(bi.s_req), 64'd0);
        tick;
        bi.s_req_ack = 1'b1;
        @(negedge clk);
        check("req_sreq", 64'(bi.s_req), 64'd1);
        tick;
        bi.s_req_ack = 1'b0;
        bi.m_req[p]  = 1'b0;
        for (int k = 0; k < nr; k++) begin
            r          = rsq[2*k +: 2];
            bi.s_resp  = r;
            bi.s_rdata = rd0 + 32'(k);
            if (r != YCR_MEMIF_NOTRDY)
                push_rsp(p, (r == YCR_MEMIF_RDY_LOK) ? YCR_MEMIF_RDY_OK : r, rd0 + 32'(k));
            tick;
        end
        bi.s_resp  = 2'd0;
        bi.s_rdata = 32'd0;
        @(negedge clk);
        check("done_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        fx_en        = 1'b0;
        bi.m_req     = '0;
        bi.m_cmd     = '0;
        bi.m_width   = '0;
        bi.m_addr    = '0;
        bi.m_bl      = '0;
        bi.s_req_ack = 1'b0;
        bi.s_rdata   = '0;
        bi.s_resp    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sreq", 64'(bi.s_req), 64'd0);
        check("rst_mresp", 64'(bi.m_resp), 64'd0);
        check("rst_mack", 64'(bi.m_req_ack), 64'd0);
        check("rst_mrdata", bi.m_rdata, 64'd0);
        check("rst_tev", 64'(tev), 64'd0);
        check("rst_ptr", 64'(dut.ptr), 64'd0);
        tick;
        rst = 1'b0;

        // Single read, burst with a NOTRDY gap, then zero-length burst.
        run_txn(0, 32'h100, 3'd1, 3'd1, 16'h0001, 1, 32'hDEADBEEF);
        run_txn(0, 32'h120, 3'd4, 3'd4, 16'h0351, 5, 32'hA0000000);
        check("ptr_after_burst", 64'(dut.ptr), 64'd1);
        run_txn(0, 32'h140, 3'd0, 3'd1, 16'h0001, 1, 32'hB0000000);

        // Request withdrawn before ack.
        tick;
        bi.m_req[0]          = 1'b1;
        bi.m_addr[31:0]      = 32'h600;
        bi.m_bl[2:0]         = 3'd1;
        tick;
        tick;
        bi.m_req[0] = 1'b0;
        @(negedge clk);
        check("drop_sreq", 64'(bi.s_req), 64'd0);
        tick;
        @(negedge clk);
        check("drop_idle", 64'(busy), 64'd0);
        check("drop_ptr", 64'(dut.ptr), 64'd1);

        // Port 1 is forced to single beats.
        run_txn(1, 32'h180, 3'd4, 3'd1, 16'h0001, 1, 32'hCAFE0000);
        check("ptr_after_single", 64'(dut.ptr), 64'd0);

        // Watchdog: downstream never answers.
        tick;
        bi.m_req[0]     = 1'b1;
        bi.m_addr[31:0] = 32'h400;
        bi.m_bl[2:0]    = 3'd2;
        exp_acc.push_back(acc_t'({2'b01, 32'h400, 3'd2}));
        tick;
        bi.s_req_ack = 1'b1;
        tick;
        bi.s_req_ack = 1'b0;
        bi.m_req[0]  = 1'b0;
        push_rsp(0, YCR_MEMIF_RDY_ER, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wd_quiet", 64'(tev), 64'd0);
            tick;
        end
        @(negedge clk);
        check("wd_evt", 64'(tev), 64'd1);
        tick;
        bi.s_resp  = YCR_MEMIF_RDY_OK;
        bi.s_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        check("wd_evt_clear", 64'(tev), 64'd0);
        check("wd_idle", 64'(busy), 64'd0);
        tick;
        bi.s_resp  = 2'd0;
        bi.s_rdata = 32'd0;
        run_txn(1, 32'h700, 3'd1, 3'd1, 16'h0003, 1, 32'h77000000);

        // Both ports requesting continuously: RR alternates, fixed priority sticks to port 0.
        tick;
        fx_en           = 1'b1;
        bi.m_req        = 2'b11;
        bi.m_addr       = {32'h300, 32'h200};
        bi.m_bl         = {3'd1, 3'd1};
        bi.m_width      = {2'd2, 2'd2};
        bi.s_req_ack    = 1'b1;
        bi.s_resp       = YCR_MEMIF_RDY_LOK;
        bi.s_rdata      = 32'h5555AAAA;
        for (int i = 0; i < 4; i++) begin
            exp_acc.push_back(acc_t'({(i % 2 == 0) ? 2'b01 : 2'b10,
                                      (i % 2 == 0) ? 32'h200 : 32'h300, 3'd1}));
            push_rsp(i % 2, YCR_MEMIF_RDY_OK, 32'h5555AAAA);
            exp_fx.push_back(2'b01);
        end
        repeat (12) tick;
        bi.m_req     = 2'b00;
        bi.s_req_ack = 1'b0;
        bi.s_resp    = 2'd0;
        bi.s_rdata   = 32'd0;
        fx_en        = 1'b0;

        // Reset in the middle of a burst.
        tick;
        bi.m_req[0]     = 1'b1;
        bi.m_addr[31:0] = 32'h500;
        bi.m_bl[2:0]    = 3'd4;
        exp_acc.push_back(acc_t'({2'b01, 32'h500, 3'd4}));
        tick;
        bi.s_req_ack = 1'b1;
        tick;
        bi.s_req_ack = 1'b0;
        bi.m_req[0]  = 1'b0;
        bi.s_resp    = YCR_MEMIF_RDY_OK;
        bi.s_rdata   = 32'h1234;
        push_rsp(0, YCR_MEMIF_RDY_OK, 32'h1234);
        tick;
        bi.s_resp  = 2'd0;
        bi.s_rdata = 32'd0;
        rst        = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_sreq", 64'(bi.s_req), 64'd0);
        check("mrst_mresp", 64'(bi.m_resp), 64'd0);
        check("mrst_ptr", 64'(dut.ptr), 64'd0);

        repeat (3) tick;
        check("acc_left", 64'(exp_acc.size()), 64'd0);
        check("rsp_left", 64'(exp_rsp.size()), 64'd0);
        check("fx_left", 64'(exp_fx.size()), 64'd0);
        check("tev_pulses", 64'(tev_cnt), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
